// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit: opcodes,
// ALU/mux select codes and the FSM state encoding.
package uc_pkg;

  localparam int WCNT_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Codes 13..15 are unused and fall back to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_RWB    = 4'd3,
    S_EXEC_I = 4'd4,
    S_IWB    = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

endpackage

// File: rtl/uc_multiciclo_dec.sv
// Moore output decoder: maps state and wait counter to every datapath control.
// Purely combinational; memory strobes depend on the counter reaching MEM_WAIT.
module uc_multiciclo_dec
  import uc_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int ALUOP_W  = 3
) (
  input  state_t              state,
  input  logic [WCNT_W-1:0]   wcnt,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemToRead,
  output logic                MemToWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  AluOp,
  output logic [1:0]          PCSource,
  output logic                InstrDone,
  output logic                IllegalOp
);

  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_WAIT);

  logic wait_done;
  assign wait_done = (wcnt == WAIT_LAST);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemToRead   = 1'b0;
    MemToWrite  = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    AluOp       = ALUOP_W'(ALUOP_ADD);
    PCSource    = PCSRC_ALU;
    InstrDone   = 1'b0;
    IllegalOp   = 1'b0;
    case (state)
      S_FETCH: begin
        MemToRead = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        IRWrite   = wait_done;
        PCWrite   = wait_done;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        AluOp   = ALUOP_W'(ALUOP_FUNCT);
      end
      S_RWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_EXEC_I, S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_IWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMRD: begin
        IorD      = 1'b1;
        MemToRead = 1'b1;
      end
      S_MEMWB: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemToWrite = 1'b1;
        InstrDone  = wait_done;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOp       = ALUOP_W'(ALUOP_SUB);
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        InstrDone   = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = PCSRC_JUMP;
        InstrDone = 1'b1;
      end
      S_TRAP: begin
        IllegalOp = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle MIPS32 main control FSM: state register, opcode-driven next state
// and the memory wait-state counter; outputs come from uc_multiciclo_dec.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3,
  parameter int MEM_WAIT = 0,
  parameter int EN_JUMP  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     OpCode,
  input  logic                Zero,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemToRead,
  output logic                MemToWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  AluOp,
  output logic [1:0]          PCSource,
  output logic                InstrDone,
  output logic                IllegalOp
);

  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_WAIT);

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic                wait_done;

  // Zero gates the PC load in the datapath together with PCWriteCond.
  logic zero_unused;
  assign zero_unused = Zero;

  assign wait_done = (wcnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OpCode)
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = (EN_JUMP != 0) ? S_JUMP : S_TRAP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: state_nxt = S_RWB;
      S_EXEC_I: state_nxt = S_IWB;
      S_MEMADR: state_nxt = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = wait_done ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = wait_done ? S_FETCH : S_MEMWR;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Only memory states self-loop; any transition clears the counter so each
  // memory state is entered with wcnt == 0.
  always_comb begin
    wcnt_nxt = '0;
    if (state_nxt == state)
      wcnt_nxt = wait_done ? wcnt : wcnt + WCNT_W'(1);
  end

  uc_multiciclo_dec #(
    .MEM_WAIT (MEM_WAIT),
    .ALUOP_W  (ALUOP_W)
  ) u_dec (
    .state       (state),
    .wcnt        (wcnt),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemToRead   (MemToRead),
    .MemToWrite  (MemToWrite),
    .IRWrite     (IRWrite),
    .MemToReg    (MemToReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .AluOp       (AluOp),
    .PCSource    (PCSource),
    .InstrDone   (InstrDone),
    .IllegalOp   (IllegalOp)
  );

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: instance A (MEM_WAIT=0, jump on), instance B
// (MEM_WAIT=2, jump off); per-cycle expected controls come from a queue.
module tb_uc_multiciclo;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    ctl_t       exp;
    string      tag;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op_a = '0;
  logic [5:0] op_b = '0;
  ctl_t       obs_a, obs_b;
  ent_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  logic       a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_sa, a_done, a_ill;
  logic [1:0] a_sb, a_pcs;
  logic [2:0] a_aluop;
  logic       b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_sa, b_done, b_ill;
  logic [1:0] b_sb, b_pcs;
  logic [2:0] b_aluop;

  uc_multiciclo #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT(0), .EN_JUMP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .OpCode(op_a), .Zero(1'b0),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemToRead(a_mr),
    .MemToWrite(a_mw), .IRWrite(a_irw), .MemToReg(a_m2r), .RegDst(a_rd),
    .RegWrite(a_rw), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .AluOp(a_aluop),
    .PCSource(a_pcs), .InstrDone(a_done), .IllegalOp(a_ill)
  );

  uc_multiciclo #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT(2), .EN_JUMP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .OpCode(op_b), .Zero(1'b1),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemToRead(b_mr),
    .MemToWrite(b_mw), .IRWrite(b_irw), .MemToReg(b_m2r), .RegDst(b_rd),
    .RegWrite(b_rw), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .AluOp(b_aluop),
    .PCSource(b_pcs), .InstrDone(b_done), .IllegalOp(b_ill)
  );

  assign obs_a = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_sa,
                  a_sb, a_aluop, a_pcs, a_done, a_ill};
  assign obs_b = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_sa,
                  b_sb, b_aluop, b_pcs, b_done, b_ill};

  task automatic check(input string tag, input ctl_t got, input ctl_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  function automatic ctl_t fetch_ctl(input bit last);
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.ir_write  = last;
    c.pc_write  = last;
    return c;
  endfunction

  task automatic put(input logic [5:0] op, input ctl_t c, input int idx);
    ent_t e;
    e.op  = op;
    e.exp = c;
    e.tag = $sformatf("op%b.c%0d", op, idx);
    exp_q.push_back(e);
  endtask

  // Cycle-by-cycle control trace for one instruction.
  task automatic push_instr(input logic [5:0] op, input int mw, input bit ej);
    ctl_t c;
    int   n = 1;
    for (int k = 0; k <= mw; k++) begin put(op, fetch_ctl(k == mw), n); n++; end
    c = '0; c.alu_src_b = 2'b11; put(op, c, n); n++;
    case (op)
      6'b000000: begin
        c = '0; c.alu_src_a = 1; c.alu_op = 3'b010; put(op, c, n); n++;
        c = '0; c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; put(op, c, n);
      end
      6'b001000: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; put(op, c, n); n++;
        c = '0; c.reg_write = 1; c.instr_done = 1; put(op, c, n);
      end
      6'b100011: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; put(op, c, n); n++;
        for (int k = 0; k <= mw; k++) begin
          c = '0; c.iord = 1; c.mem_read = 1; put(op, c, n); n++;
        end
        c = '0; c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; put(op, c, n);
      end
      6'b101011: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; put(op, c, n); n++;
        for (int k = 0; k <= mw; k++) begin
          c = '0; c.iord = 1; c.mem_write = 1; c.instr_done = (k == mw); put(op, c, n); n++;
        end
      end
      6'b000100: begin
        c = '0; c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1;
        c.pc_source = 2'b01; c.instr_done = 1; put(op, c, n);
      end
      6'b000010: begin
        c = '0; c.instr_done = 1;
        if (ej) begin c.pc_write = 1; c.pc_source = 2'b10; end
        else c.illegal_op = 1;
        put(op, c, n);
      end
      default: begin
        c = '0; c.illegal_op = 1; c.instr_done = 1; put(op, c, n);
      end
    endcase
  endtask

  // Pops up to n entries (all if n < 0), one per clock, sampled at negedge.
  task automatic run_q(input bit sel_b, input int n);
    ent_t e;
    int   cnt = 0;
    while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
      e = exp_q.pop_front();
      if (sel_b) op_b = e.op; else op_a = e.op;
      check($sformatf("%s.%s", sel_b ? "B" : "A", e.tag), sel_b ? obs_b : obs_a, e.exp);
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    op_a = '0;
    op_b = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("A.reset", obs_a, fetch_ctl(1'b1));
    check("B.reset", obs_b, fetch_ctl(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);

    // Instance A: every instruction class, including SW then ADDI back to back.
    do_reset();
    push_instr(6'b000000, 0, 1'b1);
    push_instr(6'b100011, 0, 1'b1);
    push_instr(6'b101011, 0, 1'b1);
    push_instr(6'b001000, 0, 1'b1);
    push_instr(6'b000100, 0, 1'b1);
    push_instr(6'b000010, 0, 1'b1);
    push_instr(6'b111111, 0, 1'b1);
    push_instr(6'b000000, 0, 1'b1);
    run_q(1'b0, -1);

    // Instance B: wait states and J trapped as illegal.
    do_reset();
    push_instr(6'b100011, 2, 1'b0);
    push_instr(6'b000010, 2, 1'b0);
    push_instr(6'b101011, 2, 1'b0);
    push_instr(6'b000000, 2, 1'b0);
    push_instr(6'b000100, 2, 1'b0);
    run_q(1'b1, -1);

    // Reset in the middle of a stretched store.
    do_reset();
    push_instr(6'b101011, 2, 1'b0);
    run_q(1'b1, 6);
    #2 rst_n = 1'b0;
    #1 check("B.rst_mid_memwr", obs_b, fetch_ctl(1'b0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_instr(6'b001000, 2, 1'b0);
    run_q(1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
Multi-cycle main control unit for the MIPS32 datapath. It replaces single-cycle opcode decoding with a Moore FSM that sequences each instruction over FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps. It drives the shared-memory, IR, PC and ALU-operand controls. It adds a parametrised memory wait-state counter, an optional jump mode, and illegal-opcode trapping.

Parameters:
OP_W, 6, opcode field width
ALUOP_W, 3, AluOp width; codes 000 add, 001 sub, 010 R-type funct
MEM_WAIT, 0, extra wait cycles per memory access (0..15)
EN_JUMP, 1, 1 = decode J (000010); 0 = J treated as illegal

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
OpCode  in  OP_W  IR[31:26], valid from DECODE onward
Zero  in  1  ALU zero flag (used externally with PCWriteCond)
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if Zero (BEQ)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemToRead  out  1  memory read enable
MemToWrite  out  1  memory write enable
IRWrite  out  1  instruction register load
MemToReg  out  1  write-back select: 1 = MDR
RegDst  out  1  destination select: 1 = rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
AluOp  out  ALUOP_W  ALU control class
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
InstrDone  out  1  one-cycle pulse in the final state of each instruction
IllegalOp  out  1  one-cycle pulse in TRAP

Behaviour:
- Single state register; all outputs are Moore outputs decoded from state and the wait counter only. Unlisted outputs are 0 in each state.
- Reset (rst_n low, asynchronous): state = FETCH, wait counter = 0. Outputs during and after reset are the FETCH values.
- FETCH: MemToRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=000, PCSource=00. IRWrite and PCWrite assert only when wcnt==MEM_WAIT. The FSM advances to DECODE on that cycle, otherwise wcnt increments.
- DECODE: ALUSrcA=0, ALUSrcB=11, AluOp=000 (branch target into ALUOut). Next state by OpCode:
  - 000000 -> EXEC_R
  - 100011/101011 -> MEMADR
  - 001000 -> EXEC_I
  - 000100 -> BRANCH
  - 000010 -> JUMP if EN_JUMP, else TRAP
  - any other opcode -> TRAP
- EXEC_R: ALUSrcA=1, ALUSrcB=00, AluOp=010 -> RWB.
- RWB: RegDst=1, RegWrite=1, InstrDone=1 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, AluOp=000 -> IWB.
- IWB: RegDst=0, RegWrite=1, InstrDone=1 -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, AluOp=000 -> MEMRD for LW, MEMWR for SW.
- MEMRD: IorD=1, MemToRead=1; holds for MEM_WAIT+1 cycles -> MEMWB.
- MEMWB: MemToReg=1, RegWrite=1, InstrDone=1 -> FETCH.
- MEMWR: IorD=1, MemToWrite=1 for MEM_WAIT+1 cycles; InstrDone=1 on the last cycle -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, AluOp=001, PCWriteCond=1, PCSource=01, InstrDone=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1 -> FETCH.
- TRAP: IllegalOp=1, InstrDone=1 -> FETCH. PC is already incremented, so execution continues at the next instruction.
- Wait counter: clears on entry to every memory state and saturates at MEM_WAIT. With MEM_WAIT=0 it is never nonzero.
- Latency with MEM_WAIT=0: R/ADDI/SW 4 cycles, LW 5, BEQ/J/TRAP 3. Each memory state (FETCH, MEMRD, MEMWR) adds MEM_WAIT cycles.
- Reset mid-instruction: returns immediately to FETCH. No partial RegWrite or MemToWrite may remain asserted after rst_n falls.
- An unreachable state encoding recovers to FETCH.

Decomposition:
- Package uc_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J)
  - AluOp codes
  - ALUSrcB and PCSource encodings
  - state encoding
- One sub-module, uc_multiciclo_dec: purely combinational state+wcnt -> output decoder. The top keeps the state register, next-state logic and counter.

Test Plan:
- Reset asserted mid-MEMWR, then released -> MemToWrite drops asynchronously; state FETCH with MemToRead=1 and ALUSrcB=01.
- MEM_WAIT=0, OpCode=000000 -> IRWrite/PCWrite in cycle 1; EXEC_R AluOp=010 in cycle 3; RegWrite=1, RegDst=1 and InstrDone in cycle 4.
- MEM_WAIT=2, OpCode=100011 -> IRWrite only in cycle 3; MEMRD holds MemToRead=1, IorD=1 for 3 cycles; RegWrite with MemToReg=1 in cycle 9.
- OpCode=000100 -> BRANCH state shows PCWriteCond=1, PCSource=01, AluOp=001; total 3 cycles.
- EN_JUMP=0, OpCode=000010 -> TRAP; IllegalOp pulses exactly one cycle; no RegWrite or MemToWrite; back to FETCH.
- Back-to-back SW then ADDI -> MemToWrite one cycle, then ADDI RegWrite with RegDst=0 and ALUSrcB=10; InstrDone pulses once per instruction.
